// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one signed 32x32 multiplier among NREQ requesters.
// One transaction is in flight at a time; results return on a shared, id-tagged response channel.
module mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_x,
    input  logic [NREQ*32-1:0]   req_y,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [66:0]          resp_product,
    output logic                 resp_err,
    output logic                 mul_start,
    output logic [31:0]          mul_x,
    output logic [31:0]          mul_y,
    input  logic                 mul_done,
    input  logic [66:0]          mul_product,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int             TW        = $clog2(TIMEOUT);
    localparam logic [IDW:0]   NREQ_EXT  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ-1);
    localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT-1);

    state_t         state, state_n;
    logic [IDW-1:0] rr_ptr;
    logic [31:0]    op_x, op_y;
    logic [IDW-1:0] id_q;
    logic [TW-1:0]  timer;
    logic [66:0]    prod_q;
    logic           err_q;

    logic [IDW-1:0] grant;
    logic           any_valid;
    logic [IDW:0]   cand;
    logic [31:0]    sel_x, sel_y;

    // Cyclic first-valid search starting at rr_ptr; cand wraps modulo NREQ.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= NREQ_EXT) cand = cand - NREQ_EXT;
            if (!any_valid && req_valid[cand[IDW-1:0]]) begin
                any_valid = 1'b1;
                grant     = cand[IDW-1:0];
            end
        end
    end

    assign sel_x = req_x[32*grant +: 32];
    assign sel_y = req_y[32*grant +: 32];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        req_ready  = '0;
        mul_start  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req_ready[grant] = 1'b1;
                    state_n          = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_n   = WAIT;
            end
            WAIT: begin
                if (mul_done || timer == TIMER_MAX) state_n = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: the reset clears every register, datapath included, so all outputs read 0 afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            op_x   <= '0;
            op_y   <= '0;
            id_q   <= '0;
            timer  <= '0;
            prod_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_x   <= sel_x;
                        op_y   <= sel_y;
                        id_q   <= grant;
                        rr_ptr <= (grant == LAST_ID) ? '0 : grant + 1'b1;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    if (mul_done) begin
                        prod_q <= mul_product;
                        err_q  <= 1'b0;
                    end else if (timer == TIMER_MAX) begin
                        prod_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operands are only presented while the multiplier owns the transaction.
    assign mul_x        = (state == ISSUE || state == WAIT) ? op_x : '0;
    assign mul_y        = (state == ISSUE || state == WAIT) ? op_y : '0;
    assign resp_id      = resp_valid ? id_q   : '0;
    assign resp_product = resp_valid ? prod_q : '0;
    assign resp_err     = resp_valid ? err_q  : 1'b0;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: behavioural multiplier model plus a response scoreboard.
// Expected responses are queued at grant time and compared when the response handshake occurs.
module tb_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_x, req_y;
    logic [NREQ-1:0]      req_ready;
    logic                 resp_valid, resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [66:0]          resp_product;
    logic                 resp_err;
    logic                 mul_start;
    logic [31:0]          mul_x, mul_y;
    logic                 mul_done;
    logic [66:0]          mul_product;
    logic                 busy;

    mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_product(resp_product), .resp_err(resp_err),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
        .mul_done(mul_done), .mul_product(mul_product), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [66:0]    prod;
        logic           err;
    } resp_t;

    resp_t       sb_q[$];
    int          grant_log[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] tb_x[NREQ];
    logic [31:0] tb_y[NREQ];

    task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [66:0] exp_prod(input logic [31:0] x, input logic [31:0] y);
        logic signed [66:0] xs, ys;
        xs = {{35{x[31]}}, x};
        ys = {{35{y[31]}}, y};
        return xs * ys;
    endfunction

    function automatic resp_t mk(input int id, input logic [66:0] p, input logic e);
        resp_t r;
        r.id   = IDW'(id);
        r.prod = p;
        r.err  = e;
        return r;
    endfunction

    // Multiplier model: done pulse 'lat' cycles after the start cycle, garbage product otherwise.
    int          lat = 30;
    bit          hang = 1'b0;
    bit          inj_done = 1'b0;
    bit          auto_push = 1'b0;
    int          cnt = 0;
    int          start_count = 0;
    logic        done_m = 1'b0;
    logic [66:0] model_prod = '0;

    assign mul_done = done_m | inj_done;

    always @(negedge clk) begin
        done_m      = 1'b0;
        mul_product = 67'h2_DEAD_BEEF_0BAD_F00D;
        if (rst) begin
            cnt = 0;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                done_m      = 1'b1;
                mul_product = model_prod;
            end
        end
        if (mul_start && !rst) begin
            start_count++;
            model_prod = 67'($signed(mul_x)) * 67'($signed(mul_y));
            cnt        = hang ? 0 : lat;
        end
    end

    // Grant logger, scoreboard push on grant, scoreboard pop on response handshake.
    always @(negedge clk) begin : monitor
        int    g;
        resp_t e;
        if (!rst) begin
            if (req_ready != '0) begin
                check("grant_onehot", 67'($countones(req_ready)), 67'd1);
                g = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                grant_log.push_back(g);
                if (auto_push)
                    sb_q.push_back(hang ? mk(g, '0, 1'b1) : mk(g, exp_prod(tb_x[g], tb_y[g]), 1'b0));
            end
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    check("resp_unexpected", 67'd1, 67'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_id", 67'(resp_id), 67'(e.id));
                    check("resp_product", resp_product, e.prod);
                    check("resp_err", 67'(resp_err), 67'(e.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y, input logic v);
        tb_x[i]           = x;
        tb_y[i]           = y;
        req_x[32*i +: 32] = x;
        req_y[32*i +: 32] = y;
        req_valid[i]      = v;
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready[i]) check("grant_wait", 67'd0, 67'd1);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        @(negedge clk);
        while (!mul_start && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!mul_start) check("start_wait", 67'd0, 67'd1);
    endtask

    task automatic wait_resp(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < bound);
        if (!resp_valid) check("resp_wait", 67'd0, 67'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 67'(sb_q.size() == 0 && !busy), 67'd1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, sc0;
        rst        = 1'b1;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            tb_x[i] = '0;
            tb_y[i] = '0;
        end
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 67'(req_ready), 67'd0);
        check("rst_resp_valid", 67'(resp_valid), 67'd0);
        check("rst_busy", 67'(busy), 67'd0);
        check("rst_mul_start", 67'(mul_start), 67'd0);
        check("rst_mul_x", 67'(mul_x), 67'd0);
        check("rst_resp_product", resp_product, 67'd0);

        // Basic multiply
        tick();
        resp_ready = 1'b1;
        lat        = 30;
        sb_q.push_back(mk(0, 67'd6408, 1'b0));
        sc0 = start_count;
        set_req(0, 32'd72, 32'd89, 1'b1);
        wait_ready(0);
        tick();
        req_valid[0] = 1'b0;
        wait_start(n);
        check("basic_start_lat", 67'(n), 67'd0);
        check("basic_mul_x", 67'(mul_x), 67'd72);
        check("basic_mul_y", 67'(mul_y), 67'd89);
        wait_resp(200, n);
        check("basic_done_to_resp", 67'(n), 67'd31);
        @(negedge clk);
        check("basic_busy_after", 67'(busy), 67'd0);
        check("basic_start_count", 67'(start_count - sc0), 67'd1);

        // Signed operands
        tick();
        lat = 5;
        sb_q.push_back(mk(2, 67'h7_FFFF_FFFF_FFFF_FFF1, 1'b0));
        set_req(2, 32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_ready(2);
        tick();
        req_valid[2] = 1'b0;
        drain();

        // Round-robin from a fresh pointer
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        grant_log.delete();
        lat       = 3;
        auto_push = 1'b1;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 32'h0000_1000 * (i + 1) + 32'(i), 32'(-(3 * i + 7)), 1'b1);
        n = 0;
        while (grant_log.size() < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        tick();
        req_valid = '0;
        drain();
        check("rr_count", 67'(grant_log.size()), 67'd5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check($sformatf("rr_grant%0d", k), 67'(grant_log[k]), 67'(k % NREQ));

        // Timeout, then an unsolicited done in IDLE
        tick();
        auto_push = 1'b0;
        hang      = 1'b1;
        sb_q.push_back(mk(3, '0, 1'b1));
        set_req(3, 32'd12345, 32'd678, 1'b1);
        wait_ready(3);
        tick();
        req_valid[3] = 1'b0;
        wait_start(n);
        wait_resp(200, n);
        check("timeout_latency", 67'(n), 67'(TIMEOUT + 1));
        @(negedge clk);
        check("timeout_busy_after", 67'(busy), 67'd0);
        tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_done_busy", 67'(busy), 67'd0);
            check("stray_done_resp", 67'(resp_valid), 67'd0);
        end

        // Backpressure with req1 pending
        tick();
        hang       = 1'b0;
        lat        = 3;
        auto_push  = 1'b1;
        resp_ready = 1'b0;
        set_req(0, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1);
        wait_ready(0);
        tick();
        req_valid[0] = 1'b0;
        set_req(1, 32'd31337, 32'hFFFF_0000, 1'b1);
        wait_resp(100, n);
        for (int k = 0; k < 10; k++) begin
            check("bp_resp_valid", 67'(resp_valid), 67'd1);
            check("bp_resp_id", 67'(resp_id), 67'd0);
            check("bp_resp_product", resp_product, exp_prod(32'h8000_0001, 32'h7FFF_FFFF));
            check("bp_resp_err", 67'(resp_err), 67'd0);
            check("bp_req_ready", 67'(req_ready), 67'd0);
            @(negedge clk);
        end
        tick();
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_grant_after", 67'(req_ready), 67'b0010);
        tick();
        req_valid[1] = 1'b0;
        drain();

        // Reset during WAIT
        tick();
        auto_push = 1'b0;
        hang      = 1'b1;
        set_req(2, 32'd999, 32'd111, 1'b1);
        wait_ready(2);
        tick();
        req_valid[2] = 1'b0;
        wait_start(n);
        repeat (3) @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_req_ready", 67'(req_ready), 67'd0);
        check("mid_rst_resp_valid", 67'(resp_valid), 67'd0);
        check("mid_rst_resp_id", 67'(resp_id), 67'd0);
        check("mid_rst_resp_product", resp_product, 67'd0);
        check("mid_rst_resp_err", 67'(resp_err), 67'd0);
        check("mid_rst_mul_start", 67'(mul_start), 67'd0);
        check("mid_rst_mul_x", 67'(mul_x), 67'd0);
        check("mid_rst_mul_y", 67'(mul_y), 67'd0);
        check("mid_rst_busy", 67'(busy), 67'd0);
        repeat (5) begin
            @(negedge clk);
            check("mid_rst_no_resp", 67'(resp_valid), 67'd0);
        end
        tick();
        hang      = 1'b0;
        lat       = 4;
        auto_push = 1'b1;
        set_req(1, 32'd4, 32'hFFFF_FFF9, 1'b1);
        set_req(3, 32'd6, 32'd7, 1'b1);
        @(negedge clk);
        check("mid_rst_next_grant", 67'(req_ready), 67'b0010);
        tick();
        req_valid = '0;
        drain();

        check("sb_empty", 67'(sb_q.size()), 67'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
